rx_destuff_shift: RTL and testbench

USB 1.1 receive stage directly downstream of the NRZI decoder. Consumes the decoded serial bit (d_orig) on each shift_enable strobe and removes stuffed zeros: after six consecutive 1s, the next bit is discarded. Assembles the remaining data bits LSB-first into bytes for the RX control FSM / RX FIFO. Flags bit-stuff violations and packets that end mid-byte.

---
 rtl/rx_destuff_shift.sv | 165 ++++++++++++++++
 tb/tb_rx_destuff_shift.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_destuff_shift.sv
// -----------------------------------------------------------------------------
// rx_destuff_shift
//
// USB 1.1 receive stage that sits directly after the NRZI decoder. It takes one
// decoded bit per shift_enable strobe and drops the stuffed zero that follows
// every run of STUFF_LEN ones. The remaining data bits are packed LSB-first
// into BYTE_W-bit words. It also flags bit-stuff violations and packets that
// end part-way through a byte.
//
// Ports
//   clk          : system clock
//   n_rst        : asynchronous reset, active low
//   d_orig       : NRZI-decoded bit, valid while shift_enable=1
//   shift_enable : one-clk strobe per USB bit period (bit sample point)
//   eop          : end-of-packet (SE0), qualified by shift_enable
//   rcving       : packet in progress from the RX control FSM (0 = idle)
//   rx_byte      : last completed data byte, LSB = first bit received
//   byte_valid   : one-clk pulse, rx_byte has just been updated
//   stuff_err    : sticky bit-stuff violation flag, cleared when rcving=0
//   align_err    : one-clk pulse, EOP arrived with a partial byte pending
// -----------------------------------------------------------------------------
module rx_destuff_shift #(
  parameter int unsigned BYTE_W    = 8,
  parameter int unsigned STUFF_LEN = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              d_orig,
  input  logic              shift_enable,
  input  logic              eop,
  input  logic              rcving,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              byte_valid,
  output logic              stuff_err,
  output logic              align_err
);

  localparam int unsigned CNT_W  = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BYTE_W - 1);
  localparam logic [ONES_W-1:0] RUN_MAX  = ONES_W'(STUFF_LEN);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STUFF,
    ERR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ONES_W-1:0]   ones_cnt_q, ones_cnt_d;
  // Holds the first BYTE_W-1 bits of the byte being assembled. The final bit
  // is taken straight from d_orig when the word completes, so one storage bit
  // is never needed.
  logic [BYTE_W-2:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   rx_byte_q, rx_byte_d;
  logic                byte_valid_q, byte_valid_d;
  logic                stuff_err_q, stuff_err_d;
  logic                align_err_q, align_err_d;

  // Next-state / output logic
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    stuff_err_d  = stuff_err_q;
    byte_valid_d = 1'b0;
    align_err_d  = 1'b0;

    if (!rcving) begin
      // Leaving the packet wins over anything else happening this cycle.
      state_d     = IDLE;
      bit_cnt_d   = '0;
      ones_cnt_d  = '0;
      shift_d     = '0;
      stuff_err_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          bit_cnt_d  = '0;
          ones_cnt_d = '0;
          shift_d    = '0;
          // An EOP strobe seen while idle keeps the FSM parked.
          if (!(shift_enable && eop)) begin
            state_d = DATA;
          end
        end

        DATA, STUFF, ERR: begin
          if (shift_enable) begin
            if (eop) begin
              if (state_q != ERR && bit_cnt_q != '0) begin
                align_err_d = 1'b1;
              end
              state_d    = IDLE;
              bit_cnt_d  = '0;
              ones_cnt_d = '0;
              shift_d    = '0;
            end else if (state_q == DATA) begin
              shift_d    = {d_orig, shift_q[BYTE_W-2:1]};
              ones_cnt_d = d_orig ? ones_cnt_q + ONES_W'(1) : '0;
              if (bit_cnt_q == LAST_BIT) begin
                rx_byte_d    = {d_orig, shift_q};
                bit_cnt_d    = '0;
                byte_valid_d = 1'b1;
              end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
              end
              // The run counter spans byte boundaries, so a byte can complete
              // and arm the stuffed-bit drop on the same event.
              if (ones_cnt_d == RUN_MAX) begin
                state_d = STUFF;
              end
            end else if (state_q == STUFF) begin
              if (d_orig) begin
                stuff_err_d = 1'b1;
                state_d     = ERR;
              end else begin
                ones_cnt_d = '0;
                state_d    = DATA;
              end
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      ones_cnt_q   <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      stuff_err_q  <= stuff_err_d;
      align_err_q  <= align_err_d;
    end
  end

  assign rx_byte    = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign stuff_err  = stuff_err_q;
  assign align_err  = align_err_q;

endmodule

// File: tb/tb_rx_destuff_shift.sv
// -----------------------------------------------------------------------------
// tb_rx_destuff_shift
//
// Bench for rx_destuff_shift. Directed scenarios followed by randomized bit
// streams; every cycle's outputs are compared with a bit-stream reference
// model that counts one-runs and accumulates data bits arithmetically.
// -----------------------------------------------------------------------------
module tb_rx_destuff_shift;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_orig;
  logic       shift_enable;
  logic       eop;
  logic       rcving;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       stuff_err;
  logic       align_err;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int         m_mode;   // 0 idle, 1 receiving, 2 error
  bit         m_stuff;  // next bit event is a stuffed bit
  int         m_run;    // length of the current run of data ones
  int         m_nbits;  // data bits collected for the current byte
  int         m_acc;    // value of those bits, bit i = i-th bit received
  logic [7:0] m_byte;
  bit         m_serr;
  bit         m_bv;
  bit         m_ae;

  int tx_run;           // one-run length seen by the stuffing sender

  rx_destuff_shift #(.BYTE_W(8), .STUFF_LEN(6)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_orig       (d_orig),
    .shift_enable (shift_enable),
    .eop          (eop),
    .rcving       (rcving),
    .rx_byte      (rx_byte),
    .byte_valid   (byte_valid),
    .stuff_err    (stuff_err),
    .align_err    (align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("rx_byte",    32'(rx_byte),    32'(m_byte));
    chk("byte_valid", 32'(byte_valid), 32'(m_bv));
    chk("stuff_err",  32'(stuff_err),  32'(m_serr));
    chk("align_err",  32'(align_err),  32'(m_ae));
  endtask

  task automatic model_clear();
    m_run   = 0;
    m_nbits = 0;
    m_acc   = 0;
    m_stuff = 0;
  endtask

  task automatic model_step(input bit se, input bit d, input bit e, input bit rcv);
    m_bv = 0;
    m_ae = 0;
    if (!rcv) begin
      m_mode = 0;
      m_serr = 0;
      model_clear();
    end else if (m_mode == 0) begin
      if (!(se && e)) m_mode = 1;
    end else if (se) begin
      if (e) begin
        if (m_mode == 1 && m_nbits != 0) m_ae = 1;
        m_mode = 0;
        model_clear();
      end else if (m_mode == 1) begin
        if (m_stuff) begin
          if (d) begin
            m_serr = 1;
            m_mode = 2;
          end else begin
            m_run   = 0;
            m_stuff = 0;
          end
        end else begin
          m_acc   = m_acc + (int'(d) << m_nbits);
          m_nbits = m_nbits + 1;
          m_run   = d ? m_run + 1 : 0;
          if (m_nbits == 8) begin
            m_byte  = 8'(m_acc);
            m_bv    = 1;
            m_nbits = 0;
            m_acc   = 0;
          end
          if (m_run == 6) m_stuff = 1;
        end
      end
    end
  endtask

  task automatic tick(input bit se, input bit d, input bit e);
    @(negedge clk);
    shift_enable = se;
    d_orig       = d;
    eop          = e;
    @(posedge clk);
    model_step(se, d, e, rcving);
    #1;
    check_outputs();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < n; i++) tick(1'b1, v[i], 1'b0);
  endtask

  // Sender side: inserts a zero after six ones, as the USB transmitter would.
  task automatic send_stuffed(input logic [7:0] b);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, v[i], 1'b0);
      tx_run = v[i] ? tx_run + 1 : 0;
      if (tx_run == 6) begin
        tick(1'b1, 1'b0, 1'b0);
        tx_run = 0;
      end
    end
  endtask

  // Drop then raise rcving, leaving the DUT in its receiving state.
  task automatic new_packet();
    rcving = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    rcving = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tx_run = 0;
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    #1;
    m_mode = 0;
    m_byte = '0;
    m_serr = 0;
    m_bv   = 0;
    m_ae   = 0;
    model_clear();
    chk("reset_rx_byte",    32'(rx_byte),    32'h0);
    chk("reset_byte_valid", 32'(byte_valid), 32'h0);
    chk("reset_stuff_err",  32'(stuff_err),  32'h0);
    chk("reset_align_err",  32'(align_err),  32'h0);
  endtask

  initial begin
    n_rst        = 1'b1;
    d_orig       = 1'b0;
    shift_enable = 1'b0;
    eop          = 1'b0;
    rcving       = 1'b0;
    tx_run       = 0;
    #2;
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // Plain byte 0xA5
    new_packet();
    send_bits(8'hA5, 8);
    chk("a5_value", 32'(rx_byte), 32'hA5);
    chk("a5_valid", 32'(byte_valid), 32'h1);
    tick(1'b0, 1'b0, 1'b0);
    chk("a5_pulse_end", 32'(byte_valid), 32'h0);

    // 0xFF then 0x00 with a stuffed zero after the sixth one
    new_packet();
    send_stuffed(8'hFF);
    chk("ff_value", 32'(rx_byte), 32'hFF);
    send_stuffed(8'h00);
    chk("00_value", 32'(rx_byte), 32'h00);
    chk("ff00_stuff_err", 32'(stuff_err), 32'h0);

    // Seven ones: stuffing violation, then ignored bits, then rcving drop
    new_packet();
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b0);
    chk("viol_stuff_err", 32'(stuff_err), 32'h1);
    for (int i = 0; i < 12; i++) tick(1'b1, 1'($urandom_range(1)), 1'b0);
    rcving = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    chk("viol_cleared", 32'(stuff_err), 32'h0);

    // Partial byte then EOP, then a clean 0x3C
    new_packet();
    send_bits(8'h05, 3);
    tick(1'b1, 1'b1, 1'b1);
    chk("align_pulse", 32'(align_err), 32'h1);
    tick(1'b0, 1'b0, 1'b0);
    chk("align_pulse_end", 32'(align_err), 32'h0);
    send_bits(8'h3C, 8);
    chk("3c_value", 32'(rx_byte), 32'h3C);

    // Asynchronous reset part-way through a byte
    new_packet();
    send_bits(8'h1F, 5);
    @(negedge clk);
    #2;
    apply_reset();
    @(negedge clk);
    n_rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    send_bits(8'h81, 7);
    chk("81_not_early", 32'(byte_valid), 32'h0);
    send_bits(8'h01, 1);
    chk("81_value", 32'(rx_byte), 32'h81);

    // Long shift_enable gap mid-byte with d_orig toggling
    new_packet();
    send_bits(8'h0A, 4);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'(i % 2), 1'b0);
    send_bits(8'h05, 4);
    chk("gap_value", 32'(rx_byte), 32'h5A);

    // Randomized well-formed bytes with random strobe gaps
    new_packet();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(3) == 0) tick(1'b0, 1'($urandom_range(1)), 1'b0);
      send_stuffed(8'($urandom));
    end
    tick(1'b1, 1'b0, 1'b1);

    // Randomized raw streams: ones-heavy data, occasional EOP and rcving drops
    new_packet();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(59) == 0) rcving = 1'b0;
      else rcving = 1'b1;
      tick(($urandom_range(3) != 0), ($urandom_range(3) != 0), ($urandom_range(39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
